pio_arg_arbiter: RTL
====================

# pio_arg_arbiter

Two-port Avalon-MM arbiter that shares the debug system's single argument PIO slave (32-bit output register, 2-bit address, zero-wait combinational readdata) between the JTAG host master (m0) and the core-side debug master (m1). It grants one transaction at a time using round-robin, with an optional bounded lock so one master can write a multi-word argument set without interleaving. It registers the slave-side request and returns read data with a fixed latency.

## Interface
Parameters:
- DATA_W, 32, data width of masters and slave
- ADDR_W, 2, word address width
- LOCK_MAX, 4, maximum consecutive locked grants to one master while the other is pending (≥1)

Ports:
- clk  in  1  clock
- reset_n  in  1  reset; asynchronous, active-low
- mN_chipselect  in  1  request from master N (N=0,1)
- mN_write_n  in  1  0 = write, 1 = read
- mN_address  in  ADDR_W  word address
- mN_writedata  in  DATA_W  write data
- mN_lock  in  1  keep grant for next transaction
- mN_waitrequest  out  1  high = request not accepted
- mN_readdata  out  DATA_W  read return data
- mN_readdatavalid  out  1  one-cycle read-return strobe
- s_chipselect, s_write_n, s_address, s_writedata  out  1/1/ADDR_W/DATA_W  registered slave request
- s_readdata  in  DATA_W  slave read data, valid combinationally while s_chipselect is high
- grant  out  2  one-hot owner of current or last transaction (status)

## Operation
- FSM states: ARB, ISSUE.
- ARB: pending = {m1_chipselect, m0_chipselect}. If none are pending, stay in ARB.
  - Select winner W:
    - If lock_owner is valid, lock_owner is pending, and lock_cnt < LOCK_MAX, W = lock_owner.
    - Else if only one master is pending, W is that master.
    - Else W is the master after last_grant.
  - Capture W's write_n, address and writedata into the s_* registers. Go to ISSUE.
- ISSUE:
  - s_chipselect is high for exactly this cycle. mW_waitrequest is low, so the transaction is accepted.
  - For a read, capture s_readdata.
  - Update last_grant to W.
  - Lock handling:
    - If mW_lock is high, set lock_owner = W and increment lock_cnt (saturates at LOCK_MAX).
    - Otherwise clear lock_owner and set lock_cnt = 0.
    - If W is not the previous lock_owner, lock_cnt restarts at 1.
  - Return to ARB.
- Read return: mW_readdatavalid is high for one cycle, the cycle after ISSUE. mW_readdata holds the captured value until the next read to that master.
- mN_waitrequest = ~(state==ISSUE && W==N). It is high in all other cycles, including when the master is idle.
- Request fields are sampled only in ARB. If a master changes or drops its request during ISSUE, the registered copy is still issued; this is a protocol violation and is not an error.
- Lock only raises priority. A locked owner that stops requesting loses the grant to any pending peer. When lock_cnt reaches LOCK_MAX and the peer is pending, the peer wins the next ARB and lock_owner is cleared.
- Writes have no response.

## Timing
- Reset values:
  - s_chipselect=0, s_write_n=1, s_address=0, s_writedata=0
  - mN_waitrequest=1, mN_readdatavalid=0, mN_readdata=0
  - grant=2'b00, state=ARB
  - last_grant=m1 (so m0 wins the first tie), lock_owner invalid, lock_cnt=0
- Latency, with request high in cycle T (state ARB):
  - s_chipselect and waitrequest low in T+1.
  - readdatavalid in T+2.
- Throughput: one transaction per 2 cycles at most. Back-to-back requests alternate ARB and ISSUE.
- Simultaneous requests with no lock: grants alternate m0, m1, m0, …
- Reset asserted mid-ISSUE clears everything immediately. The interrupted transaction is lost and no readdatavalid is produced.

## Test plan
- Single m0 write: addr 0, data 0xDEADBEEF. Required: s_chipselect=1, s_write_n=0, s_writedata=0xDEADBEEF one cycle after the request; m0_waitrequest low in that same cycle only; grant=01.
- m1 read with s_readdata=0x12345678. Required: m1_readdatavalid=1 exactly 2 cycles after the request, m1_readdata=0x12345678; m0 sees no readdatavalid.
- Both masters hold continuous writes, no lock, from reset. Required: issue order m0, m1, m0, m1; each master is accepted once every 4 cycles.
- m0 holds lock with continuous writes while m1 requests continuously, LOCK_MAX=4. Required: 4 consecutive m0 issues, then one m1 issue, then m0 resumes.
- Reset pulse during ISSUE of an m0 read. Required: all outputs return to reset values within the same cycle, no m0_readdatavalid afterwards, and the next request after release is granted to m0 normally.
- m0 locked owner drops chipselect while m1 is pending. Required: m1 is granted at the next ARB, and lock_owner is cleared once that m1 transaction completes with m1_lock low.

Source files
------------

// File: rtl/pio_arg_arbiter.sv
// Round-robin arbiter sharing one zero-wait argument PIO slave between two Avalon-MM masters.
// Supports a bounded lock so one master can issue a multi-word argument set without interleaving.
module pio_arg_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 2,
  parameter int LOCK_MAX = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m0_chipselect_i,
  input  logic              m0_write_n_i,
  input  logic [ADDR_W-1:0] m0_address_i,
  input  logic [DATA_W-1:0] m0_writedata_i,
  input  logic              m0_lock_i,
  output logic              m0_waitrequest_o,
  output logic [DATA_W-1:0] m0_readdata_o,
  output logic              m0_readdatavalid_o,
  input  logic              m1_chipselect_i,
  input  logic              m1_write_n_i,
  input  logic [ADDR_W-1:0] m1_address_i,
  input  logic [DATA_W-1:0] m1_writedata_i,
  input  logic              m1_lock_i,
  output logic              m1_waitrequest_o,
  output logic [DATA_W-1:0] m1_readdata_o,
  output logic              m1_readdatavalid_o,
  output logic              s_chipselect_o,
  output logic              s_write_n_o,
  output logic [ADDR_W-1:0] s_address_o,
  output logic [DATA_W-1:0] s_writedata_o,
  input  logic [DATA_W-1:0] s_readdata_i,
  output logic [1:0]        grant_o
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  typedef enum logic {ARB, ISSUE} state_t;

  state_t             state_q;
  logic               winner_q, winner_d;
  logic               lastGrant_q;
  logic               lockValid_q;
  logic               lockOwner_q;
  logic [CNT_W-1:0]   lockCnt_q, lockCnt_d;
  logic               sChipselect_q, sWriteN_q;
  logic [ADDR_W-1:0]  sAddress_q;
  logic [DATA_W-1:0]  sWritedata_q;
  logic [DATA_W-1:0]  m0Readdata_q, m1Readdata_q;
  logic               m0Rdv_q, m1Rdv_q;
  logic [1:0]         grant_q;
  logic [1:0]         pending;
  logic               lockWins;
  logic               curLock;

  // Winner selection for ARB and lock bookkeeping for the transaction in ISSUE.
  always_comb begin
    pending  = {m1_chipselect_i, m0_chipselect_i};
    lockWins = lockValid_q && pending[lockOwner_q] && (lockCnt_q < CNT_W'(LOCK_MAX));
    winner_d = ~lastGrant_q;
    if (lockWins)               winner_d = lockOwner_q;
    else if (pending == 2'b01)  winner_d = 1'b0;
    else if (pending == 2'b10)  winner_d = 1'b1;
    curLock   = winner_q ? m1_lock_i : m0_lock_i;
    lockCnt_d = '0;
    if (curLock) begin
      if (!lockValid_q || (lockOwner_q != winner_q)) lockCnt_d = CNT_W'(1);
      else if (lockCnt_q < CNT_W'(LOCK_MAX))          lockCnt_d = lockCnt_q + CNT_W'(1);
      else                                            lockCnt_d = lockCnt_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ARB;
      winner_q      <= 1'b0;
      lastGrant_q   <= 1'b1;
      lockValid_q   <= 1'b0;
      lockOwner_q   <= 1'b0;
      lockCnt_q     <= '0;
      sChipselect_q <= 1'b0;
      sWriteN_q     <= 1'b1;
      sAddress_q    <= '0;
      sWritedata_q  <= '0;
      m0Readdata_q  <= '0;
      m1Readdata_q  <= '0;
      m0Rdv_q       <= 1'b0;
      m1Rdv_q       <= 1'b0;
      grant_q       <= 2'b00;
    end else begin
      m0Rdv_q <= 1'b0;
      m1Rdv_q <= 1'b0;
      case (state_q)
        ARB: begin
          if (|pending) begin
            state_q       <= ISSUE;
            winner_q      <= winner_d;
            grant_q       <= winner_d ? 2'b10 : 2'b01;
            sChipselect_q <= 1'b1;
            sWriteN_q     <= winner_d ? m1_write_n_i   : m0_write_n_i;
            sAddress_q    <= winner_d ? m1_address_i   : m0_address_i;
            sWritedata_q  <= winner_d ? m1_writedata_i : m0_writedata_i;
          end
        end
        ISSUE: begin
          state_q       <= ARB;
          sChipselect_q <= 1'b0;
          lastGrant_q   <= winner_q;
          lockValid_q   <= curLock;
          lockOwner_q   <= curLock ? winner_q : 1'b0;
          lockCnt_q     <= lockCnt_d;
          // The slave answers combinationally, so the read completes in this cycle.
          if (sWriteN_q) begin
            if (winner_q) begin
              m1Readdata_q <= s_readdata_i;
              m1Rdv_q      <= 1'b1;
            end else begin
              m0Readdata_q <= s_readdata_i;
              m0Rdv_q      <= 1'b1;
            end
          end
        end
        default: state_q <= ARB;
      endcase
    end
  end

  assign m0_waitrequest_o   = !((state_q == ISSUE) && (winner_q == 1'b0));
  assign m1_waitrequest_o   = !((state_q == ISSUE) && (winner_q == 1'b1));
  assign m0_readdata_o      = m0Readdata_q;
  assign m1_readdata_o      = m1Readdata_q;
  assign m0_readdatavalid_o = m0Rdv_q;
  assign m1_readdatavalid_o = m1Rdv_q;
  assign s_chipselect_o     = sChipselect_q;
  assign s_write_n_o        = sWriteN_q;
  assign s_address_o        = sAddress_q;
  assign s_writedata_o      = sWritedata_q;
  assign grant_o            = grant_q;

endmodule
